// File: rtl/sha_host_bridge.sv
// -----------------------------------------------------------------------------
// sha_host_bridge
//
// Host-side glue between a narrow request/acknowledge host port and a
// word-oriented SHA-256d core. A job is launched with i_start. Each time the
// core raises a word request, the bridge fetches WORD_W/HOST_W host beats and
// hands the assembled word back with a one-cycle o_core_rdy strobe. When the
// core reports its digest, the digest is registered and streamed back to the
// host one beat at a time. Any host handshake stuck for TIMEOUT cycles, or a
// core request that arrives while a word is still being fetched, parks the
// bridge in a sticky error state. i_abort returns to idle from anywhere.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   i_start        begin a job (honoured in idle or error)
//   i_abort        cancel the job, highest priority
//   i_host_din     host data beat
//   i_host_ack     host accepts/provides the current beat (only while o_host_req)
//   o_host_req     bridge requests one beat
//   o_host_dout    digest beat during readback, otherwise {core_addr, beat index}
//   o_busy         job in progress
//   o_done         digest readback phase
//   o_err          sticky error (timeout or overrun)
//   o_core_start   one-cycle start pulse to the core
//   i_core_rq      core word request, rising edge starts a fetch
//   i_core_addr    word index requested by the core
//   o_core_data    assembled word
//   o_core_rdy     one-cycle strobe, o_core_data valid
//   i_core_done    digest valid this cycle
//   i_core_digest  digest from the core
// -----------------------------------------------------------------------------
module sha_host_bridge #(
   parameter int HOST_W        = 8,
   parameter int WORD_W        = 32,
   parameter int DIGEST_W      = 256,
   parameter int ADDR_W        = 5,
   parameter int TIMEOUT       = 255,
   parameter bit OUT_LSB_FIRST = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic [HOST_W-1:0]   i_host_din,
   input  logic                i_host_ack,
   output logic                o_host_req,
   output logic [HOST_W-1:0]   o_host_dout,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err,
   output logic                o_core_start,
   input  logic                i_core_rq,
   input  logic [ADDR_W-1:0]   i_core_addr,
   output logic [WORD_W-1:0]   o_core_data,
   output logic                o_core_rdy,
   input  logic                i_core_done,
   input  logic [DIGEST_W-1:0] i_core_digest
);

   localparam int NB_W  = WORD_W / HOST_W;
   localparam int NB_D  = DIGEST_W / HOST_W;
   localparam int BI_W  = $clog2(NB_D) + 1;
   localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TAG_W = ADDR_W + BI_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT,
      S_FETCH,
      S_OUT,
      S_ERR
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_rqDly;
   logic                  r_hostReq;
   logic [BI_W-1:0]       r_beatIdx;
   logic [TO_W-1:0]       r_toCnt;
   logic [WORD_W-1:0]     r_coreData;
   logic                  r_coreRdy;
   logic [DIGEST_W-1:0]   r_digest;

   logic                  w_rqRise;
   logic                  w_beatAck;
   logic                  w_toHit;
   logic                  w_lastWordBeat;
   logic                  w_lastDigBeat;
   logic [HOST_W-1:0]     w_digestBeat;
   logic [HOST_W+TAG_W-1:0] w_tagExt;

   // A beat completes only when the host acknowledges an outstanding request;
   // stray acks while the request is low fall out here.
   assign w_rqRise       = i_core_rq & ~r_rqDly;
   assign w_beatAck      = r_hostReq & i_host_ack;
   assign w_lastWordBeat = (r_beatIdx == BI_W'(NB_W - 1));
   assign w_lastDigBeat  = (r_beatIdx == BI_W'(NB_D - 1));

   // The timeout fires on the edge that would bring the stalled-cycle count
   // up to TIMEOUT, so the request is seen high for exactly TIMEOUT cycles.
   assign w_toHit = (TIMEOUT != 0) && r_hostReq && !i_host_ack &&
                    (r_toCnt == TO_W'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode. Overrun checks come before beat completion so a
   // misbehaving core is never served a half-built word, and abort overrides
   // everything at the end.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_ARM;
         S_ARM:   w_next = S_WAIT;
         S_WAIT: begin
            if (w_rqRise)         w_next = S_FETCH;
            else if (i_core_done) w_next = S_OUT;
         end
         S_FETCH: begin
            if (w_rqRise || i_core_done || w_toHit)  w_next = S_ERR;
            else if (w_beatAck && w_lastWordBeat)    w_next = S_WAIT;
         end
         S_OUT: begin
            if (w_toHit)                             w_next = S_ERR;
            else if (w_beatAck && w_lastDigBeat)     w_next = S_IDLE;
         end
         S_ERR:   if (i_start) w_next = S_ARM;
         default: w_next = S_IDLE;
      endcase
      if (i_abort) w_next = S_IDLE;
   end

   // Datapath registers. The beat index restarts on every state change so it
   // never wraps inside a job. The host request is re-raised one cycle after
   // each completed beat, which guarantees at least one low cycle between beats,
   // and drops whenever the state is about to change (abort, timeout, overrun).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rqDly    <= 1'b0;
         r_hostReq  <= 1'b0;
         r_beatIdx  <= '0;
         r_toCnt    <= '0;
         r_coreData <= '0;
         r_coreRdy  <= 1'b0;
         r_digest   <= '0;
      end else begin
         r_rqDly   <= i_core_rq;
         r_coreRdy <= 1'b0;

         if (w_next != r_state) begin
            r_beatIdx <= '0;
         end else if (w_beatAck) begin
            r_beatIdx <= r_beatIdx + 1'b1;
         end

         r_hostReq <= (w_next == r_state) &&
                      (r_state == S_FETCH || r_state == S_OUT) &&
                      (!r_hostReq || !i_host_ack);

         if (!r_hostReq || w_beatAck || (w_next != r_state)) begin
            r_toCnt <= '0;
         end else begin
            r_toCnt <= r_toCnt + 1'b1;
         end

         if (r_state == S_FETCH && w_beatAck && !i_abort) begin
            for (int b = 0; b < NB_W; b++) begin
               if (r_beatIdx == BI_W'(b)) begin
                  r_coreData[WORD_W-1-b*HOST_W -: HOST_W] <= i_host_din;
               end
            end
            if (w_lastWordBeat && w_next == S_WAIT) begin
               r_coreRdy <= 1'b1;
            end
         end

         if (r_state == S_WAIT && w_next == S_OUT) begin
            r_digest <= i_core_digest;
         end
      end
   end

   // Digest beat selection for readback, in the configured order.
   always_comb begin
      w_digestBeat = '0;
      for (int b = 0; b < NB_D; b++) begin
         if (r_beatIdx == BI_W'(b)) begin
            if (OUT_LSB_FIRST) begin
               w_digestBeat = r_digest[b*HOST_W +: HOST_W];
            end else begin
               w_digestBeat = r_digest[DIGEST_W-1-b*HOST_W -: HOST_W];
            end
         end
      end
   end

   // Outside readback the host sees the requested address and beat index,
   // zero-extended or truncated to the beat width.
   assign w_tagExt = {{HOST_W{1'b0}}, i_core_addr, r_beatIdx};

   assign o_host_dout  = (r_state == S_OUT) ? w_digestBeat : w_tagExt[HOST_W-1:0];
   assign o_host_req   = r_hostReq;
   assign o_busy       = (r_state == S_ARM) || (r_state == S_WAIT) ||
                         (r_state == S_FETCH) || (r_state == S_OUT);
   assign o_done       = (r_state == S_OUT);
   assign o_err        = (r_state == S_ERR);
   assign o_core_start = (r_state == S_ARM);
   assign o_core_data  = r_coreData;
   assign o_core_rdy   = r_coreRdy;

endmodule

// File: tb/tb_sha_host_bridge.sv
// -----------------------------------------------------------------------------
// tb_sha_host_bridge
//
// Two 8-bit bridges (MSB-first and LSB-first readback, TIMEOUT=4) share one
// set of inputs; a third 16-bit bridge covers wide beats. Stimulus pushes the
// expected words, address tags and digest beats into queues, and a monitor on
// the falling edge pops and compares whenever a DUT presents them.
// -----------------------------------------------------------------------------
module tb_sha_host_bridge;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   logic         start8, abort8, ack8, coreRq8, coreDone8;
   logic [7:0]   din8;
   logic [4:0]   addr8;
   logic [255:0] digest8;

   logic         reqA, busyA, doneA, errA, cstartA, rdyA;
   logic [7:0]   doutA;
   logic [31:0]  dataA;
   logic         reqB, busyB, doneB, errB, cstartB, rdyB;
   logic [7:0]   doutB;
   logic [31:0]  dataB;

   logic         start16, abort16, ack16, coreRq16, coreDone16;
   logic [15:0]  din16;
   logic [4:0]   addr16;
   logic [255:0] digest16;
   logic         req16, busy16, done16, err16, cstart16, rdy16;
   logic [15:0]  dout16;
   logic [31:0]  data16;

   int nAssert = 0;
   int nFail   = 0;

   logic [31:0] wordQA[$];
   logic [31:0] wordQ16[$];
   logic [7:0]  tagQA[$];
   logic [15:0] tagQ16[$];
   logic [7:0]  digQA[$];
   logic [7:0]  digQB[$];
   int          rdyCountA  = 0;
   int          rdyCount16 = 0;
   int          reqPulse16 = 0;
   logic        prevReq16  = 1'b0;

   sha_host_bridge #(.HOST_W(8), .TIMEOUT(4), .OUT_LSB_FIRST(1'b0)) u_dutA (
      .clk(clk), .rst_n(rst_n), .i_start(start8), .i_abort(abort8),
      .i_host_din(din8), .i_host_ack(ack8), .o_host_req(reqA), .o_host_dout(doutA),
      .o_busy(busyA), .o_done(doneA), .o_err(errA), .o_core_start(cstartA),
      .i_core_rq(coreRq8), .i_core_addr(addr8), .o_core_data(dataA), .o_core_rdy(rdyA),
      .i_core_done(coreDone8), .i_core_digest(digest8)
   );

   sha_host_bridge #(.HOST_W(8), .TIMEOUT(4), .OUT_LSB_FIRST(1'b1)) u_dutB (
      .clk(clk), .rst_n(rst_n), .i_start(start8), .i_abort(abort8),
      .i_host_din(din8), .i_host_ack(ack8), .o_host_req(reqB), .o_host_dout(doutB),
      .o_busy(busyB), .o_done(doneB), .o_err(errB), .o_core_start(cstartB),
      .i_core_rq(coreRq8), .i_core_addr(addr8), .o_core_data(dataB), .o_core_rdy(rdyB),
      .i_core_done(coreDone8), .i_core_digest(digest8)
   );

   sha_host_bridge #(.HOST_W(16), .TIMEOUT(0), .OUT_LSB_FIRST(1'b0)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .i_start(start16), .i_abort(abort16),
      .i_host_din(din16), .i_host_ack(ack16), .o_host_req(req16), .o_host_dout(dout16),
      .o_busy(busy16), .o_done(done16), .o_err(err16), .o_core_start(cstart16),
      .i_core_rq(coreRq16), .i_core_addr(addr16), .o_core_data(data16), .o_core_rdy(rdy16),
      .i_core_done(coreDone16), .i_core_digest(digest16)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nAssert++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: pops expected values whenever a DUT presents a word,
   // an address tag during a fetch handshake, or a digest beat.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rdyA) begin
            rdyCountA++;
            if (wordQA.size() == 0) checkOutput("unexpectedRdyA", 32'(rdyA), 32'd0);
            else checkOutput("coreDataA", dataA, wordQA.pop_front());
         end
         if (reqA && ack8 && !doneA) begin
            if (tagQA.size() == 0) checkOutput("unexpectedTagA", 32'(doutA), 32'hFFFF_FFFF);
            else checkOutput("fetchTagA", 32'(doutA), 32'(tagQA.pop_front()));
         end
         if (reqA && ack8 && doneA) begin
            if (digQA.size() == 0) checkOutput("unexpectedDigA", 32'(doutA), 32'hFFFF_FFFF);
            else checkOutput("digestBeatA", 32'(doutA), 32'(digQA.pop_front()));
         end
         if (reqB && ack8 && doneB) begin
            if (digQB.size() == 0) checkOutput("unexpectedDigB", 32'(doutB), 32'hFFFF_FFFF);
            else checkOutput("digestBeatB", 32'(doutB), 32'(digQB.pop_front()));
         end
         if (req16 && !prevReq16) reqPulse16++;
         prevReq16 = req16;
         if (rdy16) begin
            rdyCount16++;
            checkOutput("reqPulsesPerWord16", 32'(reqPulse16), 32'd2);
            reqPulse16 = 0;
            if (wordQ16.size() == 0) checkOutput("unexpectedRdy16", 32'(rdy16), 32'd0);
            else checkOutput("coreData16", data16, wordQ16.pop_front());
         end
         if (req16 && ack16 && !done16) begin
            if (tagQ16.size() == 0) checkOutput("unexpectedTag16", 32'(dout16), 32'hFFFF_FFFF);
            else checkOutput("fetchTag16", 32'(dout16), 32'(tagQ16.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for a host request from DUT A (wide=0) or the 16-bit DUT.
   task automatic waitReq(input bit wide);
      for (int i = 0; i < 20; i++) begin
         if (wide ? req16 : reqA) break;
         tick();
      end
      checkOutput(wide ? "hostReqSeen16" : "hostReqSeenA", 32'(wide ? req16 : reqA), 32'd1);
   endtask

   task automatic beat8(input logic [7:0] d);
      waitReq(1'b0);
      din8 = d;
      ack8 = 1'b1;
      tick();
      ack8 = 1'b0;
   endtask

   task automatic beat16(input logic [15:0] d);
      waitReq(1'b1);
      din16 = d;
      ack16 = 1'b1;
      tick();
      ack16 = 1'b0;
   endtask

   task automatic launch8();
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
   endtask

   // Serve one word request on the 8-bit pair. The 8-bit bridge's tag is
   // {addr, 6-bit index} truncated to 8 bits: addr[1:0] lands in bits 7:6.
   task automatic fetchWord8(input logic [4:0] addr, input logic [31:0] word);
      wordQA.push_back(word);
      for (int i = 0; i < 4; i++) tagQA.push_back(8'((32'(addr) << 6) | i));
      coreRq8 = 1'b1;
      addr8   = addr;
      tick();
      for (int i = 0; i < 4; i++) beat8(8'(word >> (24 - 8 * i)));
      checkOutput("coreRdyHigh", 32'(rdyA), 32'd1);
      coreRq8 = 1'b0;
      tick();
      checkOutput("coreRdyOneCycle", 32'(rdyA), 32'd0);
   endtask

   task automatic applyStimulus();
      int hiCycles;
      int rdySnap;
      start8 = 0; abort8 = 0; ack8 = 0; coreRq8 = 0; coreDone8 = 0; din8 = 0; addr8 = 0;
      digest8 = '0;
      start16 = 0; abort16 = 0; ack16 = 0; coreRq16 = 0; coreDone16 = 0; din16 = 0; addr16 = 0;
      digest16 = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetCtrlA", 32'({reqA, busyA, doneA, errA, cstartA, rdyA}), 32'd0);
      checkOutput("resetDataA", dataA, 32'd0);
      checkOutput("resetCtrlB", 32'({reqB, busyB, doneB, errB, cstartB, rdyB}), 32'd0);
      checkOutput("resetCtrl16", 32'({req16, busy16, done16, err16, cstart16, rdy16}), 32'd0);
      rst_n = 1'b1;
      tick();

      // Launch: core_start for exactly one cycle, busy from then on.
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      checkOutput("coreStartPulse", 32'({cstartA, busyA}), 32'd3);
      tick();
      checkOutput("coreStartEnd", 32'({cstartA, busyA}), 32'd1);

      fetchWord8(5'd3, 32'h6A09E667);
      fetchWord8(5'd5, 32'hBB67AE85);

      // Digest readback on both orderings.
      digest8   = {2{128'h00112233445566778899AABBCCDDEEFF}};
      coreDone8 = 1'b1;
      tick();
      coreDone8 = 1'b0;
      checkOutput("doneEntered", 32'({doneA, busyA}), 32'd3);
      for (int k = 0; k < 32; k++) begin
         digQA.push_back(8'((k % 16) * 17));
         digQB.push_back(8'((15 - k % 16) * 17));
      end
      for (int k = 0; k < 32; k++) beat8(8'h00);
      checkOutput("readbackEndA", 32'({doneA, busyA, reqA}), 32'd0);
      checkOutput("readbackEndB", 32'({doneB, busyB, reqB}), 32'd0);
      checkOutput("digQADrained", 32'(digQA.size()), 32'd0);
      checkOutput("digQBDrained", 32'(digQB.size()), 32'd0);

      // Abort together with the third byte's ack: that byte is discarded.
      launch8();
      for (int i = 0; i < 3; i++) tagQA.push_back(8'(8'hC0 | i));
      coreRq8 = 1'b1;
      addr8   = 5'd3;
      tick();
      beat8(8'h11);
      beat8(8'h22);
      rdySnap = rdyCountA;
      waitReq(1'b0);
      din8 = 8'h33; ack8 = 1'b1; abort8 = 1'b1;
      tick();
      ack8 = 1'b0; abort8 = 1'b0;
      checkOutput("abortIdle", 32'({busyA, reqA, doneA, errA, rdyA}), 32'd0);
      coreRq8 = 1'b0;
      tick(); tick();
      checkOutput("abortNoRdy", 32'(rdyCountA), 32'(rdySnap));
      checkOutput("abortDataHeld", dataA, 32'h1122AE85);

      // Overrun: a fresh core_rq rising edge in the middle of a fetch.
      launch8();
      tagQA.push_back(8'hC0);
      coreRq8 = 1'b1;
      tick();
      beat8(8'h44);
      coreRq8 = 1'b0;
      tick();
      coreRq8 = 1'b1;
      tick();
      checkOutput("overrunErr", 32'({errA, reqA, busyA}), 32'd4);
      coreRq8 = 1'b0;
      abort8  = 1'b1;
      tick();
      abort8  = 1'b0;
      checkOutput("abortClearsErr", 32'(errA), 32'd0);

      // Timeout: never acknowledge; request stays high for TIMEOUT cycles.
      launch8();
      coreRq8 = 1'b1;
      tick();
      hiCycles = 0;
      for (int i = 0; i < 20 && !errA; i++) begin
         if (reqA) hiCycles++;
         tick();
      end
      checkOutput("timeoutReqCycles", 32'(hiCycles), 32'd4);
      checkOutput("timeoutErr", 32'({errA, reqA, busyA, doneA}), 32'd8);
      coreRq8 = 1'b0;
      start8  = 1'b1;
      tick();
      start8  = 1'b0;
      checkOutput("restartFromErr", 32'({errA, cstartA, busyA}), 32'd3);
      abort8 = 1'b1;
      tick();
      abort8 = 1'b0;

      // Wide beats on the 16-bit bridge: tag is {addr, 5-bit index}.
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      tick();
      wordQ16.push_back(32'hBB67AE85);
      for (int i = 0; i < 2; i++) tagQ16.push_back(16'((2 << 5) | i));
      coreRq16 = 1'b1;
      addr16   = 5'd2;
      tick();
      beat16(16'hBB67);
      beat16(16'hAE85);
      checkOutput("coreRdyHigh16", 32'(rdy16), 32'd1);
      coreRq16 = 1'b0;
      tick();
      checkOutput("coreRdyOneCycle16", 32'(rdy16), 32'd0);
      tick();

      checkOutput("wordQADrained", 32'(wordQA.size()), 32'd0);
      checkOutput("tagQADrained", 32'(tagQA.size()), 32'd0);
      checkOutput("wordQ16Drained", 32'(wordQ16.size()), 32'd0);
      checkOutput("tagQ16Drained", 32'(tagQ16.size()), 32'd0);
      checkOutput("rdyCountA", 32'(rdyCountA), 32'd2);
      checkOutput("rdyCount16", 32'(rdyCount16), 32'd1);
   endtask

   // Main sequence followed by the single summary line.
   initial begin
      applyStimulus();
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

   // Hard stop in case a wait somewhere never returns.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/sha_host_bridge.md
Name: sha_host_bridge

Overview:
- Parametrised host-side bridge between a narrow external handshake port and a word-oriented SHA-256d core.
- Launches the core, serves each core word request by fetching `WORD_W/HOST_W` host beats, then registers the digest and streams it back beat by beat.
- Generalises the fixed 8-bit/32-byte top-level glue:
  - configurable host beat width;
  - configurable digest output order;
  - registered digest;
  - host-handshake timeout with error state;
  - abort;
  - request-overrun detection.

Parameters:
- `HOST_W`, 8: bits per host beat; must divide `WORD_W` and `DIGEST_W`.
- `WORD_W`, 32: core data word width.
- `DIGEST_W`, 256: digest width.
- `ADDR_W`, 5: core word-address width.
- `TIMEOUT`, 255: max cycles `host_req` may stay high without `host_ack` (0 = never times out).
- `OUT_LSB_FIRST`, 0: 0 = digest beats MSB-first, 1 = LSB-first.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: begin a hash job (sampled in IDLE/ERR).
- `abort` input 1: cancel the job from any state.
- `host_din` input HOST_W: host data beat.
- `host_ack` input 1: host accepts/provides the current beat; sampled only while `host_req`=1.
- `host_req` output 1: bridge requests one beat.
- `host_dout` output HOST_W: in OUT = digest beat; else `{core_addr, beat_idx}` zero-extended/truncated to HOST_W.
- `busy` output 1: job in progress (ARM..OUT).
- `done` output 1: digest readback phase.
- `err` output 1: sticky error (timeout or overrun).
- `core_start` output 1: one-cycle start pulse to core.
- `core_rq` input 1: core word request; rising edge significant.
- `core_addr` input ADDR_W: word index requested.
- `core_data` output WORD_W: assembled word.
- `core_rdy` output 1: one-cycle strobe, `core_data` valid.
- `core_done` input 1: digest valid this cycle.
- `core_digest` input DIGEST_W: digest from core.

Behaviour:
- Reset (async, `rst_n`=0):
  - state = IDLE; counters = 0; `digest_q` = 0.
  - `host_req`, `busy`, `done`, `err`, `core_start`, `core_rdy` = 0.
  - `core_data` = 0.
  - Edge detector register = 0.
- States: IDLE, ARM, WAIT, FETCH, OUT, ERR. Derived constants: `NB_W = WORD_W/HOST_W`, `NB_D = DIGEST_W/HOST_W`.
- IDLE:
  - `start`=1 -> ARM, with `core_start`=1 for exactly the next cycle.
  - `busy`=1 from that cycle onward.
- ARM: one cycle, then -> WAIT.
- WAIT:
  - Rising edge of `core_rq` (registered delay) -> FETCH, with `beat_idx`=0.
  - `core_done`=1 -> capture `core_digest` into `digest_q`, then -> OUT with `beat_idx`=0 and `done`=1 next cycle.
- FETCH, beat handshake:
  - `host_req` rises the cycle after entry, or the cycle after the previous beat.
  - Beat completes on the cycle where `host_req`=1 and `host_ack`=1:
    - capture `host_din` into `core_data[WORD_W-1-beat_idx*HOST_W -: HOST_W]`;
    - `host_req`=0 next cycle, for at least 1 cycle;
    - `beat_idx`++.
- FETCH, word completion:
  - After beat `NB_W-1` completes, `core_rdy`=1 for exactly one cycle, the cycle after the capture.
  - Then -> WAIT with `beat_idx`=0.
  - `core_data` holds its value until the next word's first capture.
- Overrun:
  - A `core_rq` rising edge during FETCH, or `core_done` during FETCH, -> ERR.
- OUT:
  - `host_dout` = `digest_q` beat `beat_idx`:
    - `OUT_LSB_FIRST`=0: beat 0 = `digest_q[DIGEST_W-1 -: HOST_W]`;
    - `OUT_LSB_FIRST`=1: beat 0 = `digest_q[HOST_W-1:0]`.
  - Same req/ack rule as FETCH; each ack advances `beat_idx`.
  - After beat `NB_D-1` acks: `done`=0 and `busy`=0 next cycle, -> IDLE.
- Timeout:
  - Counter is cleared whenever `host_req`=0 or an ack occurs.
  - It increments each cycle `host_req`=1 and `host_ack`=0.
  - Reaching `TIMEOUT` (when `TIMEOUT`≠0) -> ERR next cycle.
- ERR:
  - `err`=1; `host_req`, `busy`, `done` = 0.
  - Ignores `core_*` inputs.
  - `start` -> clears `err`, behaves as IDLE `start`.
- Abort:
  - Highest priority in any state.
  - Next cycle: IDLE, all outputs 0 except `core_data` and `digest_q` (held), `err` cleared.
  - Abort wins over a simultaneous `start` or ack; the beat is discarded.
- Other rules:
  - `start` is ignored while `busy`.
  - `host_ack` while `host_req`=0 is ignored.
  - Counters are sized `$clog2(NB_D)+1` and `$clog2(TIMEOUT+1)`; `beat_idx` never wraps within a job.

Test Plan:
- Word fetch (`HOST_W`=8):
  - Stimulus: `start`; core raises `core_rq` with `core_addr`=3; host acks bytes 6A,09,E6,67.
  - Required: `core_data`=0x6A09E667; `core_rdy` high exactly 1 cycle; `host_dout` in FETCH = {3, idx}.
- Wide beats (`HOST_W`=16):
  - Stimulus: beats BB67, AE85.
  - Required: `core_data`=0xBB67AE85; 2 `host_req` pulses per word.
- Digest readback:
  - Stimulus: `core_done` with digest = 0x00112233…EEFF repeated pattern.
  - Required, `OUT_LSB_FIRST`=0: first byte out 0x00, last 0xFF.
  - Required, `OUT_LSB_FIRST`=1: first byte 0xFF.
  - Required: `done` drops after 32 acks and `busy`=0.
- Timeout (`TIMEOUT`=4):
  - Stimulus: no `host_ack`.
  - Required: ERR after 4 cycles of `host_req`=1; `err`=1, `host_req`=0; a later `start` clears `err` and pulses `core_start`.
- Abort:
  - Stimulus: `abort` asserted after 2 of 4 bytes, simultaneous with `host_ack`.
  - Required: next cycle IDLE, `busy`=0, `core_rdy` never pulses.
- Overrun:
  - Stimulus: second `core_rq` rising edge mid-FETCH.
  - Required: `err`=1, `host_req`=0.
